// File: rtl/usr_pkg.sv
// Shared mode encodings, FSM state type and helpers for the universal shift register.
// The other files import this package.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_SAR   = 3'b100;
  localparam logic [2:0] MODE_ROL   = 3'b101;
  localparam logic [2:0] MODE_ROR   = 3'b110;
  localparam logic [2:0] MODE_HOLD2 = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_state_e;

  // Left-moving modes expose the MSB on the serial output; right-moving modes expose the LSB.
  function automatic logic is_left_mode(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_ROL);
  endfunction

  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_SAR) ||
           (mode == MODE_ROL) || (mode == MODE_ROR);
  endfunction

endpackage

// File: rtl/usr_step_logic.sv
// Combinational single-step datapath: computes the next register value and the
// bit shifted out, for any mode. Shared by the single-step and multi-step paths.
module usr_step_logic
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_in,
  input  logic [2:0]       mode_in,
  input  logic             ser_l_in,
  input  logic             ser_r_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_nxt_out,
  output logic             ser_nxt_out,
  output logic             ser_upd_out
);

  // Next-value selection per mode.
  always_comb begin
    q_nxt_out = q_in;
    case (mode_in)
      MODE_HOLD:  q_nxt_out = q_in;
      MODE_LOAD:  q_nxt_out = d_in;
      MODE_SHL:   q_nxt_out = {q_in[WIDTH-2:0], ser_l_in};
      MODE_SHR:   q_nxt_out = {ser_r_in, q_in[WIDTH-1:1]};
      MODE_SAR:   q_nxt_out = {q_in[WIDTH-1], q_in[WIDTH-1:1]};
      MODE_ROL:   q_nxt_out = {q_in[WIDTH-2:0], q_in[WIDTH-1]};
      MODE_ROR:   q_nxt_out = {q_in[0], q_in[WIDTH-1:1]};
      MODE_HOLD2: q_nxt_out = q_in;
      default:    q_nxt_out = q_in;
    endcase
  end

  // Shifted-out bit; only meaningful when ser_upd_out is high.
  always_comb begin
    ser_upd_out = is_shift_mode(mode_in);
    if (is_left_mode(mode_in)) begin
      ser_nxt_out = q_in[WIDTH-1];
    end else begin
      ser_nxt_out = q_in[0];
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: single-step operation when idle, or a counted
// multi-step run with a latched mode that ends with a one-cycle done pulse.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             enable_in,
  input  logic [2:0]       mode_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_l_in,
  input  logic             ser_r_in,
  input  logic             start_in,
  input  logic [CNT_W-1:0] count_in,
  output logic [WIDTH-1:0] q_out,
  output logic             ser_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  usr_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       mode_lat_q, mode_lat_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       step_mode_s;
  logic             do_step_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic             ser_nxt_s;
  logic             ser_upd_s;

  usr_step_logic #(.WIDTH(WIDTH)) u_step (
    .q_in        (q_q),
    .mode_in     (step_mode_s),
    .ser_l_in    (ser_l_in),
    .ser_r_in    (ser_r_in),
    .d_in        (d_in),
    .q_nxt_out   (q_nxt_s),
    .ser_nxt_out (ser_nxt_s),
    .ser_upd_out (ser_upd_s)
  );

  // Next-state, step selection and run bookkeeping.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    mode_lat_d  = mode_lat_q;
    done_d      = 1'b0;
    step_mode_s = mode_in;
    do_step_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (count_in == CNT_ZERO) begin
            done_d = 1'b1;
          end else begin
            do_step_s  = 1'b1;
            mode_lat_d = mode_in;
            rem_d      = count_in - CNT_ONE;
            if (count_in == CNT_ONE) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end else if (enable_in) begin
          do_step_s = 1'b1;
        end else begin
          do_step_s = 1'b0;
        end
      end
      ST_RUN: begin
        step_mode_s = mode_lat_q;
        do_step_s   = 1'b1;
        rem_d       = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = CNT_ZERO;
      end
    endcase
  end

  // Datapath update: load/hold leave the serial output untouched.
  always_comb begin
    q_d    = q_q;
    ser_d  = ser_q;
    busy_d = (state_d == ST_RUN);
    if (do_step_s) begin
      q_d = q_nxt_s;
      if (ser_upd_s) begin
        ser_d = ser_nxt_s;
      end else begin
        ser_d = ser_q;
      end
    end else begin
      q_d = q_q;
    end
  end

  // State and output registers; reset abandons any run without a done pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      rem_q      <= CNT_ZERO;
      mode_lat_q <= MODE_HOLD;
      q_q        <= {WIDTH{1'b0}};
      ser_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      mode_lat_q <= mode_lat_d;
      q_q        <= q_d;
      ser_q      <= ser_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign q_out    = q_q;
  assign ser_out  = ser_q;
  assign busy_out = busy_q;
  assign done_out = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the register built from integer arithmetic.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic [7:0]   d = 8'd0;
  logic         sl = 1'b0;
  logic         sr = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   count = 3'd0;
  logic [7:0]   q_out;
  logic         ser_out, busy_out, done_out;

  logic         en16 = 1'b0;
  logic [2:0]   mode16 = 3'd0;
  logic [15:0]  d16 = 16'd0;
  logic         start16 = 1'b0;
  logic [2:0]   count16 = 3'd0;
  logic [15:0]  q16;
  logic         ser16, busy16, done16;

  int npass = 0;
  int ntotal = 0;

  logic [7:0] m_q;
  logic       m_ser, m_busy, m_done;
  int         m_left, m_mode;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .CNT_W(3)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(en), .mode_in(mode), .d_in(d),
    .ser_l_in(sl), .ser_r_in(sr), .start_in(start), .count_in(count),
    .q_out(q_out), .ser_out(ser_out), .busy_out(busy_out), .done_out(done_out)
  );

  univ_shift_reg #(.WIDTH(16), .CNT_W(3)) u_dut16 (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(en16), .mode_in(mode16), .d_in(d16),
    .ser_l_in(1'b0), .ser_r_in(1'b0), .start_in(start16), .count_in(count16),
    .q_out(q16), .ser_out(ser16), .busy_out(busy16), .done_out(done16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] m_next(input logic [7:0] q, input int md, input bit l, input bit r,
                                        input logic [7:0] dd);
    int v;
    v = int'(q);
    case (md)
      1:       return dd;
      2:       return 8'((v * 2 + int'(l)) % 256);
      3:       return 8'(v / 2 + int'(r) * 128);
      4:       return 8'(v / 2 + (v / 128) * 128);
      5:       return 8'((v * 2) % 256 + v / 128);
      6:       return 8'(v / 2 + (v % 2) * 128);
      default: return q;
    endcase
  endfunction

  task automatic m_apply(input int md);
    int v;
    v = int'(m_q);
    if (md == 2 || md == 5) m_ser = (v / 128) != 0;
    else if (md == 3 || md == 4 || md == 6) m_ser = (v % 2) != 0;
    m_q = m_next(m_q, md, sl, sr, d);
  endtask

  task automatic m_reset();
    m_q = 8'h00; m_ser = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_mode = 0;
  endtask

  task automatic m_edge();
    if (!rst_n) begin
      m_reset();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_apply(m_mode);
        m_left--;
        if (m_left == 0) begin m_busy = 1'b0; m_done = 1'b1; end
      end else if (start) begin
        if (count == 3'd0) m_done = 1'b1;
        else begin
          m_mode = int'(mode);
          m_apply(m_mode);
          m_left = int'(count) - 1;
          if (m_left == 0) m_done = 1'b1;
          else m_busy = 1'b1;
        end
      end else if (en) begin
        m_apply(int'(mode));
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, 32'(q_out), 32'(m_q));
    chk({tag, ".ser"}, 32'(ser_out), 32'(m_ser));
    chk({tag, ".busy"}, 32'(busy_out), 32'(m_busy));
    chk({tag, ".done"}, 32'(done_out), 32'(m_done));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    m_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_in();
    en = 1'b0; start = 1'b0; mode = 3'd0;
  endtask

  int busy_cnt;
  bit got_done;

  initial begin
    m_reset();
    #2 rst_n = 1'b0;
    #2 check_all("reset");
    cyc("reset_hold");
    rst_n = 1'b1;
    cyc("post_reset");

    // Single-step mix
    en = 1'b1; mode = 3'd1; d = 8'h81; cyc("mix_load");
    mode = 3'd4; cyc("mix_sar");
    chk("mix_sar_q", 32'(q_out), 32'h0C0); chk("mix_sar_ser", 32'(ser_out), 32'd1);
    mode = 3'd5; cyc("mix_rol");
    chk("mix_rol_q", 32'(q_out), 32'h081); chk("mix_rol_ser", 32'(ser_out), 32'd1);
    mode = 3'd3; sr = 1'b0; cyc("mix_shr");
    chk("mix_shr_q", 32'(q_out), 32'h040); chk("mix_shr_ser", 32'(ser_out), 32'd1);

    // Multi-step rotate
    mode = 3'd1; d = 8'h96; cyc("ror_load");
    en = 1'b0; start = 1'b1; mode = 3'd6; count = 3'd4; cyc("ror_start");
    start = 1'b0; mode = 3'd0;
    busy_cnt = busy_out ? 1 : 0; got_done = done_out;
    for (int i = 0; i < 8 && !got_done; i++) begin
      cyc("ror_run");
      if (busy_out) busy_cnt++;
      if (done_out) got_done = 1'b1;
    end
    chk("ror_done_seen", 32'(got_done), 32'd1);
    chk("ror_busy_cycles", 32'(busy_cnt), 32'd3);
    chk("ror_q", 32'(q_out), 32'h069);
    cyc("ror_after");
    chk("ror_done_single", 32'(done_out), 32'd0);

    // Edge counts
    start = 1'b1; mode = 3'd2; count = 3'd0; cyc("cnt0");
    chk("cnt0_done", 32'(done_out), 32'd1); chk("cnt0_q", 32'(q_out), 32'h069);
    start = 1'b0; cyc("cnt0_after");
    start = 1'b1; mode = 3'd6; count = 3'd1; cyc("cnt1");
    chk("cnt1_done", 32'(done_out), 32'd1); chk("cnt1_busy", 32'(busy_out), 32'd0);
    chk("cnt1_q", 32'(q_out), 32'h0B4);
    start = 1'b0; cyc("cnt1_after");

    // Inputs ignored while busy
    en = 1'b1; mode = 3'd1; d = 8'h00; cyc("ign_load");
    en = 1'b0; start = 1'b1; mode = 3'd2; count = 3'd7; sl = 1'b1; cyc("ign_start");
    for (int i = 0; i < 6; i++) begin
      mode = 3'($urandom_range(0, 7)); en = 1'($urandom); start = 1'($urandom);
      count = 3'($urandom); d = 8'($urandom);
      cyc("ign_run");
    end
    chk("ign_q", 32'(q_out), 32'h07F); chk("ign_done", 32'(done_out), 32'd1);
    idle_in(); cyc("ign_after");

    // Reset in the middle of a run
    en = 1'b1; mode = 3'd1; d = 8'hA5; cyc("rst_load");
    en = 1'b0; start = 1'b1; mode = 3'd2; count = 3'd5; sl = 1'b0; cyc("rst_start");
    start = 1'b0; cyc("rst_run");
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_mid_q", 32'(q_out), 32'h000);
    chk("rst_mid_busy", 32'(busy_out), 32'd0);
    chk("rst_mid_done", 32'(done_out), 32'd0);
    for (int i = 0; i < 4; i++) cyc("rst_held");
    rst_n = 1'b1;
    cyc("rst_release");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 7) == 0);
      en = 1'($urandom); mode = 3'($urandom); d = 8'($urandom);
      sl = 1'($urandom); sr = 1'($urandom); count = 3'($urandom);
      cyc("rand");
    end
    idle_in();
    for (int i = 0; i < 8; i++) cyc("drain");

    // Wide register, maximum count arithmetic shift
    en16 = 1'b1; mode16 = 3'd1; d16 = 16'h8000;
    cyc("w16_load");
    en16 = 1'b0; start16 = 1'b1; mode16 = 3'd4; count16 = 3'd7;
    cyc("w16_start");
    start16 = 1'b0; mode16 = 3'd0;
    chk("w16_busy_first", 32'(busy16), 32'd1);
    for (int i = 0; i < 5; i++) cyc("w16_run");
    chk("w16_busy_late", 32'(busy16), 32'd1);
    chk("w16_nodone_early", 32'(done16), 32'd0);
    cyc("w16_last");
    chk("w16_q", 32'(q16), 32'h0FF00);
    chk("w16_done", 32'(done16), 32'd1);
    chk("w16_busy_end", 32'(busy16), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
